// File: rtl/multi_light_calc_setup_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_light_calc_setup_if                                                  |
// | Frame request, latched geometry inputs and per-light result handshake.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface multi_light_calc_setup_if #(
  parameter int N_LIGHTS = 2,
  parameter int XW       = 11,
  parameter int YW       = 10
);
  logic                   start;
  logic [XW-1:0]          x_com;
  logic [YW-1:0]          y_com;
  logic [N_LIGHTS*XW-1:0] x_lights;
  logic [N_LIGHTS*YW-1:0] y_lights;
  logic                   out_ready;
  logic                   busy;
  logic                   out_valid;
  logic [2:0]             out_idx;
  logic [2*XW-1:0]        x_dif_sq;
  logic [2*YW-1:0]        y_dif_sq;
  logic                   x_greater_than_y;
  logic [XW-1:0]          pan_dividend;
  logic [XW-1:0]          pan_divisor;
  logic                   x_neg;
  logic                   y_neg;
  logic                   div_zero;
  logic                   frame_done;

  modport master (
    output start, x_com, y_com, x_lights, y_lights, out_ready,
    input  busy, out_valid, out_idx, x_dif_sq, y_dif_sq, x_greater_than_y,
           pan_dividend, pan_divisor, x_neg, y_neg, div_zero, frame_done
  );

  modport slave (
    input  start, x_com, y_com, x_lights, y_lights, out_ready,
    output busy, out_valid, out_idx, x_dif_sq, y_dif_sq, x_greater_than_y,
           pan_dividend, pan_divisor, x_neg, y_neg, div_zero, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/multi_light_calc_setup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_light_calc_setup                                                     |
// | Per-light distance/pan setup for one frame, one result per CALC/HOLD pair. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_light_calc_setup #(
  parameter int N_LIGHTS = 2,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input logic                    clk,
  input logic                    reset,
  multi_light_calc_setup_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] c_last_idx = 3'(N_LIGHTS - 1);

  state_t                 r_state;
  state_t                 w_state_next;

  logic [XW-1:0]          r_x_com;
  logic [YW-1:0]          r_y_com;
  logic [N_LIGHTS*XW-1:0] r_x_lights;
  logic [N_LIGHTS*YW-1:0] r_y_lights;
  logic [2:0]             r_idx;
  logic                   r_busy;
  logic                   r_out_valid;
  logic [2*XW-1:0]        r_x_dif_sq;
  logic [2*YW-1:0]        r_y_dif_sq;
  logic                   r_xgty;
  logic [XW-1:0]          r_pan_dividend;
  logic [XW-1:0]          r_pan_divisor;
  logic                   r_x_neg;
  logic                   r_y_neg;
  logic                   r_div_zero;
  logic                   r_frame_done;

  logic [XW-1:0]          w_x_light;
  logic [YW-1:0]          w_y_light;
  logic                   w_x_neg;
  logic                   w_y_neg;
  logic [XW-1:0]          w_dx;
  logic [YW-1:0]          w_dy;
  logic [XW-1:0]          w_dy_ext;
  logic [2*XW-1:0]        w_dx_wide;
  logic [2*YW-1:0]        w_dy_wide;
  logic                   w_xgty;
  logic [XW-1:0]          w_dividend;
  logic [XW-1:0]          w_divisor;
  logic                   w_last;

  // Geometry for the light currently selected by r_idx, from the latched frame copy
  assign w_x_light  = r_x_lights[int'(r_idx)*XW +: XW];
  assign w_y_light  = r_y_lights[int'(r_idx)*YW +: YW];
  assign w_x_neg    = w_x_light < r_x_com;
  assign w_y_neg    = w_y_light < r_y_com;
  assign w_dx       = w_x_neg ? (r_x_com - w_x_light) : (w_x_light - r_x_com);
  assign w_dy       = w_y_neg ? (r_y_com - w_y_light) : (w_y_light - r_y_com);
  assign w_dy_ext   = XW'(w_dy);
  assign w_dx_wide  = (2*XW)'(w_dx);
  assign w_dy_wide  = (2*YW)'(w_dy);
  assign w_xgty     = w_dx > w_dy_ext;
  assign w_dividend = w_xgty ? w_dy_ext : w_dx;
  assign w_divisor  = w_xgty ? w_dx : w_dy_ext;
  assign w_last     = (r_idx == c_last_idx);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = CALC;
      CALC:    w_state_next = HOLD;
      HOLD:    if (bus.out_ready) w_state_next = w_last ? IDLE : CALC;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x_com        <= '0;
      r_y_com        <= '0;
      r_x_lights     <= '0;
      r_y_lights     <= '0;
      r_idx          <= '0;
      r_busy         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_x_dif_sq     <= '0;
      r_y_dif_sq     <= '0;
      r_xgty         <= 1'b0;
      r_pan_dividend <= '0;
      r_pan_divisor  <= '0;
      r_x_neg        <= 1'b0;
      r_y_neg        <= 1'b0;
      r_div_zero     <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_x_com    <= bus.x_com;
            r_y_com    <= bus.y_com;
            r_x_lights <= bus.x_lights;
            r_y_lights <= bus.y_lights;
            r_idx      <= '0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_x_dif_sq     <= w_dx_wide * w_dx_wide;
          r_y_dif_sq     <= w_dy_wide * w_dy_wide;
          r_xgty         <= w_xgty;
          r_pan_dividend <= w_dividend;
          r_pan_divisor  <= w_divisor;
          r_x_neg        <= w_x_neg;
          r_y_neg        <= w_y_neg;
          r_div_zero     <= (w_divisor == '0);
          r_out_valid    <= 1'b1;
        end
        HOLD: begin
          // Results stay put until accepted; only valid/index/busy move on acceptance
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_idx          = r_idx;
  assign bus.x_dif_sq         = r_x_dif_sq;
  assign bus.y_dif_sq         = r_y_dif_sq;
  assign bus.x_greater_than_y = r_xgty;
  assign bus.pan_dividend     = r_pan_dividend;
  assign bus.pan_divisor      = r_pan_divisor;
  assign bus.x_neg            = r_x_neg;
  assign bus.y_neg            = r_y_neg;
  assign bus.div_zero         = r_div_zero;
  assign bus.frame_done       = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_light_calc_setup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_light_calc_setup                                                  |
// | Directed frames with expected results queued and checked on acceptance.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_light_calc_setup;

  localparam int N_LIGHTS = 2;
  localparam int XW       = 11;
  localparam int YW       = 10;

  typedef struct {
    int     idx;
    longint xsq;
    longint ysq;
    int     xg;
    int     dvd;
    int     dvs;
    int     xn;
    int     yn;
    int     dz;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  bit   stim_done;
  exp_t exp_q[$];

  multi_light_calc_setup_if #(.N_LIGHTS(N_LIGHTS), .XW(XW), .YW(YW)) bus ();

  multi_light_calc_setup #(.N_LIGHTS(N_LIGHTS), .XW(XW), .YW(YW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input longint xsq, input longint ysq, input int xg,
                          input int dvd, input int dvs, input int xn, input int yn, input int dz);
    exp_t e;
    e.idx = idx; e.xsq = xsq; e.ysq = ysq; e.xg = xg;
    e.dvd = dvd; e.dvs = dvs; e.xn = xn; e.yn = yn; e.dz = dz;
    exp_q.push_back(e);
  endtask

  task automatic load_frame(input int xc, input int yc, input int x0, input int y0,
                            input int x1, input int y1);
    bus.x_com    = XW'(xc);
    bus.y_com    = YW'(yc);
    bus.x_lights = {XW'(x1), XW'(x0)};
    bus.y_lights = {YW'(y1), YW'(y0)};
  endtask

  task automatic monitor();
    exp_t e;
    while (!stim_done) begin
      @(negedge clk);
      if (!stim_done && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_idx",          longint'(bus.out_idx),          e.idx);
          chk("x_dif_sq",         longint'(bus.x_dif_sq),         e.xsq);
          chk("y_dif_sq",         longint'(bus.y_dif_sq),         e.ysq);
          chk("x_greater_than_y", longint'(bus.x_greater_than_y), e.xg);
          chk("pan_dividend",     longint'(bus.pan_dividend),     e.dvd);
          chk("pan_divisor",      longint'(bus.pan_divisor),      e.dvs);
          chk("x_neg",            longint'(bus.x_neg),            e.xn);
          chk("y_neg",            longint'(bus.y_neg),            e.yn);
          chk("div_zero",         longint'(bus.div_zero),         e.dz);
        end
      end
    end
  endtask

  task automatic stimulus();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    load_frame(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_x_dif_sq", bus.x_dif_sq, 0);

    // Frame A: start accepted on the very first edge with reset released
    reset = 1'b1;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    load_frame(400, 500, 200, 600, 400, 500);
    push_exp(0, 40000, 10000, 1, 100, 200, 1, 0, 0);
    push_exp(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    bus.start = 1'b0;
    load_frame(7, 9, 1, 2, 3, 4);
    chk("a_busy_after_start", bus.busy, 1);
    chk("a_valid_cycle1", bus.out_valid, 0);
    tick();
    chk("a_valid_cycle2", bus.out_valid, 1);
    tick();
    chk("a_valid_cleared", bus.out_valid, 0);
    tick();
    chk("a_idx1_valid", bus.out_valid, 1);
    tick();
    chk("a_frame_done", bus.frame_done, 1);
    chk("a_busy_done", bus.busy, 0);
    tick();
    chk("a_frame_done_pulse", bus.frame_done, 0);

    // Frame B: extremes then a tie, with backpressure and a start while busy
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    load_frame(0, 1023, 2047, 0, 300, 723);
    push_exp(0, 4190209, 1046529, 1, 1023, 2047, 0, 1, 0);
    push_exp(1, 90000, 90000, 0, 300, 300, 0, 1, 0);
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    load_frame(5, 5, 5, 5, 5, 5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_idx", bus.out_idx, 0);
      chk("bp_x_dif_sq", bus.x_dif_sq, 4190209);
      tick();
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("b_idx1", bus.out_idx, 1);
    tick();
    chk("b_frame_done", bus.frame_done, 1);
    repeat (3) tick();
    chk("b_no_restart", bus.busy, 0);

    // Frame C: reset while holding index 1, then rerun from index 0
    bus.start = 1'b1;
    load_frame(500, 500, 100, 50, 900, 1000);
    push_exp(0, 160000, 202500, 0, 400, 450, 1, 1, 0);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b0;
    tick();
    chk("c_hold_idx1", bus.out_idx, 1);
    chk("c_hold_valid", bus.out_valid, 1);
    reset = 1'b0;
    tick();
    chk("c_rst_valid", bus.out_valid, 0);
    chk("c_rst_busy", bus.busy, 0);
    chk("c_rst_idx", bus.out_idx, 0);
    chk("c_rst_x_dif_sq", bus.x_dif_sq, 0);
    chk("c_rst_divisor", bus.pan_divisor, 0);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    push_exp(0, 160000, 202500, 0, 400, 450, 1, 1, 0);
    push_exp(1, 160000, 250000, 0, 400, 500, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    tick();
    chk("c_frame_done", bus.frame_done, 1);
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    stim_done = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    stim_done = 1'b0;
    fork
      monitor();
      stimulus();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
